// File: rtl/im_loader_pkg.sv
// Shared constants for the instruction-memory loader: IM geometry, FSM encodings
// and the big-endian byte placement helper.
package im_loader_pkg;

  localparam int unsigned IM_ADDR_W = 10;
  localparam int unsigned IM_DEPTH  = 1024;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Byte k of a word lands in bits [31-8k -: 8] (MIPS big-endian).
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  k,
                                             input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    w[31 - 8*k -: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input handshake plus IM write port of the loader.
// slave = loader view, master = byte source / IM view.
interface im_loader_if #(
  parameter int unsigned ADDR_W = im_loader_pkg::IM_ADDR_W
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/im_word_packer.sv
// Assembles accepted stream bytes into a 32-bit word; a fresh word starts zeroed,
// so an early in_last leaves the remaining bytes zero-padded.
module im_word_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        accept_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  idx_q;
  logic [31:0] word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (accept_i) begin
      idx_q  <= idx_q + 2'd1;
      word_q <= place_byte(word_q, idx_q, data_i);
    end
  end

  assign word_o      = word_q;
  assign word_done_o = accept_i & ((idx_q == 2'd3) | last_i);

endmodule

// File: rtl/im_loader.sv
// Streams bytes into the instruction memory as big-endian words from address 0,
// holding the CPU in reset until the image is complete.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IM_ADDR_W,
  parameter int unsigned DEPTH  = IM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  im_loader_if.slave        bus,
  output logic [ADDR_W:0]   words_loaded_o,
  output logic [31:0]       checksum_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              full_o,
  output logic              cpu_hold_o
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   words_q;
  logic [31:0]       sum_q;
  logic              last_q;
  logic              busy_q, done_q, full_q, hold_q;

  logic        accept, start_ok, in_write, at_end, finish;
  logic [31:0] word;
  logic        word_done;

  assign accept   = bus.in_valid & (state_q == ST_LOAD);
  assign start_ok = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign in_write = (state_q == ST_WRITE);
  assign at_end   = (addr_q == ADDR_W'(DEPTH - 1));
  assign finish   = in_write & (last_q | at_end);

  im_word_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (start_ok | in_write),
    .accept_i    (accept),
    .data_i      (bus.in_data),
    .last_i      (bus.in_last),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_i) state_d = ST_LOAD;
      ST_LOAD:          if (word_done) state_d = ST_WRITE;
      ST_WRITE:         state_d = (last_q | at_end) ? ST_DONE : ST_LOAD;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      words_q <= '0;
      sum_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        addr_q  <= '0;
        words_q <= '0;
        sum_q   <= '0;
        last_q  <= 1'b0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        full_q  <= 1'b0;
        hold_q  <= 1'b1;
      end
      if (accept) last_q <= bus.in_last;
      // Address saturates at the last word; the final write ends the load instead.
      if (in_write) begin
        words_q <= words_q + (ADDR_W + 1)'(1);
        sum_q   <= sum_q + word;
        if (!at_end) addr_q <= addr_q + ADDR_W'(1);
      end
      if (finish) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        hold_q <= 1'b0;
        full_q <= at_end & ~last_q;
      end
    end
  end

  assign bus.in_ready   = (state_q == ST_LOAD);
  assign bus.im_we      = in_write;
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = in_write ? word : '0;
  assign words_loaded_o = words_q;
  assign checksum_o     = sum_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign full_o         = full_q;
  assign cpu_hold_o     = hold_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected IM writes are queued as bytes are
// handed over and matched against every im_we pulse; a 1024x32 IM model is kept.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] words_loaded;
  logic [31:0] checksum;
  logic        busy, done, full, cpu_hold;

  im_loader_if #(.ADDR_W(10)) bus ();

  im_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .bus            (bus),
    .words_loaded_o (words_loaded),
    .checksum_o     (checksum),
    .busy_o         (busy),
    .done_o         (done),
    .full_o         (full),
    .cpu_hold_o     (cpu_hold)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [41:0] sb_q[$];
  logic [31:0] im_mem [0:1023];
  logic [31:0] exp_word;
  int unsigned exp_k, exp_addr, exp_cnt, wr_cnt;
  logic [31:0] exp_sum;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // IM model and scoreboard drain
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      check_eq("ready_low_in_we", {63'd0, bus.in_ready}, 64'd0);
      if (sb_q.size() == 0) begin
        check_eq("unexpected_we", 64'd1, 64'd0);
      end else begin
        logic [41:0] e;
        e = sb_q.pop_front();
        check_eq("we_addr", {54'd0, bus.im_addr}, {54'd0, e[41:32]});
        check_eq("we_data", {32'd0, bus.im_wdata}, {32'd0, e[31:0]});
      end
      im_mem[bus.im_addr] = bus.im_wdata;
      wr_cnt++;
    end
  end

  task automatic model_reset();
    sb_q.delete();
    exp_word = '0; exp_k = 0; exp_addr = 0; exp_cnt = 0; exp_sum = '0; wr_cnt = 0;
  endtask

  task automatic start_load();
    start = 1'b1;
    model_reset();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_start_ignored();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int unsigned max_gap);
    int unsigned gap;
    bit got;
    gap = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
    got = 1'b0;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        got = 1'b1;
        exp_word[31 - 8*exp_k -: 8] = d;
        if (exp_k == 3 || last) begin
          sb_q.push_back({10'(exp_addr), exp_word});
          exp_sum = exp_sum + exp_word;
          exp_cnt++;
          if (exp_addr < 1023) exp_addr++;
          exp_word = '0; exp_k = 0;
        end else begin
          exp_k++;
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    if (!got) check_eq("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, {63'd0, bus.in_ready}, 64'd0);
    check_eq({tag, "_we"},    {63'd0, bus.im_we}, 64'd0);
    check_eq({tag, "_addr"},  {54'd0, bus.im_addr}, 64'd0);
    check_eq({tag, "_wdata"}, {32'd0, bus.im_wdata}, 64'd0);
    check_eq({tag, "_words"}, {53'd0, words_loaded}, 64'd0);
    check_eq({tag, "_sum"},   {32'd0, checksum}, 64'd0);
    check_eq({tag, "_flags"}, {60'd0, busy, done, full, cpu_hold}, 64'b0001);
  endtask

  task automatic finish_load(input string tag, input logic exp_full);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check_eq({tag, "_done"}, {63'd0, seen}, 64'd1);
    check_eq({tag, "_words"}, {53'd0, words_loaded}, 64'(exp_cnt));
    check_eq({tag, "_sum"}, {32'd0, checksum}, {32'd0, exp_sum});
    check_eq({tag, "_flags"}, {59'd0, busy, done, full, cpu_hold, bus.in_ready},
             {59'd0, 1'b0, 1'b1, exp_full, 1'b0, 1'b0});
    check_eq({tag, "_wrcnt"}, 64'(wr_cnt), 64'(exp_cnt));
    check_eq({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [7:0] t1 [8];
  logic [31:0] w_lo, w_hi;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1) two-word image
    t1 = '{8'h3C, 8'h08, 8'h10, 8'h01, 8'h35, 8'h08, 8'h00, 8'h04};
    start_load();
    for (int i = 0; i < 8; i++) send_byte(t1[i], i == 7, 0);
    finish_load("t1", 1'b0);
    check_eq("t1_mem0", {32'd0, im_mem[0]}, 64'h3C081001);
    check_eq("t1_mem1", {32'd0, im_mem[1]}, 64'h35080004);
    check_eq("t1_sum_const", {32'd0, checksum}, 64'h71101005);

    // 2) short final word is zero padded
    start_load();
    send_byte(8'hAA, 1'b0, 0);
    send_byte(8'hBB, 1'b1, 0);
    finish_load("t2", 1'b0);
    check_eq("t2_mem0", {32'd0, im_mem[0]}, 64'hAABB0000);

    // 3) bursty source
    start_load();
    for (int i = 0; i < 12; i++) send_byte(8'($urandom), i == 11, 3);
    finish_load("t3", 1'b0);

    // 6) start while loading is ignored, start in DONE restarts from word 0
    start_load();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    pulse_start_ignored();
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h44, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i), i == 3, 1);
    finish_load("t6a", 1'b0);
    check_eq("t6_mem0", {32'd0, im_mem[0]}, 64'h11223344);
    start_load();
    @(negedge clk);
    check_eq("t6_clr_words", {53'd0, words_loaded}, 64'd0);
    check_eq("t6_clr_sum", {32'd0, checksum}, 64'd0);
    check_eq("t6_clr_flags", {60'd0, busy, done, full, cpu_hold}, 64'b1001);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), i == 3, 0);
    finish_load("t6b", 1'b0);
    check_eq("t6_reload_mem0", {32'd0, im_mem[0]}, 64'hC0C1C2C3);

    // 4) image fills the IM without in_last
    start_load();
    for (int i = 0; i < 4096; i++) send_byte(8'(i), 1'b0, 0);
    finish_load("t4", 1'b1);
    check_eq("t4_mem0", {32'd0, im_mem[0]}, 64'h00010203);
    check_eq("t4_mem1023", {32'd0, im_mem[1023]}, 64'hFCFDFEFF);
    check_eq("t4_words_const", {53'd0, words_loaded}, 64'd1024);
    bus.in_valid = 1'b1; bus.in_data = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      check_eq("t4_no_accept", {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check_eq("t4_words_hold", {53'd0, words_loaded}, 64'd1024);

    // 4b) last byte of the final word carries in_last: not flagged full
    start_load();
    for (int i = 0; i < 4096; i++) send_byte(8'(i * 3), i == 4095, 0);
    finish_load("t4b", 1'b0);

    // 5) reset mid-load aborts with no further writes
    start_load();
    w_lo = 32'h01020304;
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b0, 0);
    rst_n = 1'b0;
    sb_q.delete();
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t5_after");
    w_hi = im_mem[0];
    check_eq("t5_mem0_kept", {32'd0, w_hi}, {32'd0, w_lo});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
